// File: rtl/nios_pio_pulse_out.sv
// nios_pio_pulse_out
//   Avalon-MM slave driving a WIDTH-bit output port. A base DATA value can be
//   written whole, or have bits set/cleared. A one-shot PULSE inverts the
//   selected bits for PULSE_LEN cycles and then raises a sticky DONE flag.
//
// Ports
//   clk, reset         sole clock; synchronous active-high reset
//   address[2:0]       register word address
//   chipselect,write_n a write happens when chipselect=1 and write_n=0
//   writedata[31:0]    write data
//   readdata[31:0]     combinational, zero-wait read data for address
//   out_port[WIDTH-1:0] DATA with the active pulse mask XORed in
//   irq                level interrupt, DONE & IRQ_EN
//
// Register map
//   0 DATA      RW  base output value
//   1 STATUS    R   bit0 BUSY, bit1 DONE (write 1 to bit1 clears DONE)
//   2 CONTROL   RW  bit0 IRQ_EN
//   3 OUTSET    WO  DATA |= writedata
//   4 OUTCLR    WO  DATA &= ~writedata
//   5 PULSE_LEN RW  pulse length in cycles (0 behaves as 1)
//   6 PULSE     WO  trigger with mask; reads back the active mask
//   7 reserved      reads 0
module nios_pio_pulse_out #(
  parameter int                 WIDTH         = 8,
  parameter int                 PULSE_W       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE   = '0,
  parameter logic [PULSE_W-1:0] PULSE_DEFAULT = PULSE_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA      = 3'd0;
  localparam logic [2:0] A_STATUS    = 3'd1;
  localparam logic [2:0] A_CONTROL   = 3'd2;
  localparam logic [2:0] A_OUTSET    = 3'd3;
  localparam logic [2:0] A_OUTCLR    = 3'd4;
  localparam logic [2:0] A_PULSE_LEN = 3'd5;
  localparam logic [2:0] A_PULSE     = 3'd6;

  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               irq_en_q, irq_en_d;

  logic               wr;
  logic [WIDTH-1:0]   wdata_w;
  logic [PULSE_W-1:0] wdata_p;
  logic [PULSE_W-1:0] len_eff;
  logic               unused_wdata;

  assign wr      = chipselect & ~write_n;
  assign wdata_w = writedata[WIDTH-1:0];
  assign wdata_p = writedata[PULSE_W-1:0];
  // A programmed length of zero still produces a one-cycle pulse.
  assign len_eff = (pulse_len_q == '0) ? PULSE_W'(1) : pulse_len_q;
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d      = data_q;
    mask_d      = mask_q;
    pulse_len_d = pulse_len_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    irq_en_d    = irq_en_q;

    if (wr) begin
      case (address)
        A_DATA:      data_d      = wdata_w;
        A_STATUS:    if (writedata[1]) done_d = 1'b0;
        A_CONTROL:   irq_en_d    = writedata[0];
        A_OUTSET:    data_d      = data_q | wdata_w;
        A_OUTCLR:    data_d      = data_q & ~wdata_w;
        A_PULSE_LEN: pulse_len_d = wdata_p;
        A_PULSE: begin
          // Retriggering a running pulse or an empty mask is a no-op.
          if (!busy_q && (wdata_w != '0)) begin
            mask_d = wdata_w;
            cnt_d  = len_eff;
            busy_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Evaluated after the STATUS write so a completing pulse wins over a
    // DONE clear in the same cycle.
    if (busy_q) begin
      cnt_d = cnt_q - PULSE_W'(1);
      if (cnt_q == PULSE_W'(1)) begin
        busy_d = 1'b0;
        mask_d = '0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= RESET_VALUE;
      mask_q      <= '0;
      pulse_len_q <= PULSE_DEFAULT;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      data_q      <= data_d;
      mask_q      <= mask_d;
      pulse_len_q <= pulse_len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:      readdata[WIDTH-1:0]   = data_q;
      A_STATUS:    readdata[1:0]         = {done_q, busy_q};
      A_CONTROL:   readdata[0]           = irq_en_q;
      A_PULSE_LEN: readdata[PULSE_W-1:0] = pulse_len_q;
      A_PULSE:     readdata[WIDTH-1:0]   = mask_q;
      default:     readdata              = '0;
    endcase
  end

  // mask_q is already zero when idle; the busy gate keeps that explicit.
  assign out_port = data_q ^ (busy_q ? mask_q : '0);
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_nios_pio_pulse_out.sv
module tb_nios_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int tests = 0;
  int fails = 0;

  nios_pio_pulse_out dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the
  // write applied by the rising edge in between.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic run(input string tag, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {24'd0, out_port}, {24'd0, exp});
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_out", {24'd0, out_port}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    rd("rst_data", 3'd0, 32'h0);
    rd("rst_status", 3'd1, 32'h0);
    rd("rst_plen", 3'd5, 32'h1);

    // DATA write, upper bits ignored
    wr(3'd0, 32'h1234_56A5);
    check("data_out", {24'd0, out_port}, 32'hA5);
    rd("data_rd", 3'd0, 32'h0000_00A5);

    // OUTSET / OUTCLR
    wr(3'd0, 32'hF0);
    wr(3'd3, 32'h03);
    check("outset", {24'd0, out_port}, 32'hF3);
    wr(3'd4, 32'h30);
    check("outclr", {24'd0, out_port}, 32'hC3);
    rd("rd_outset", 3'd3, 32'h0);
    rd("rd_outclr", 3'd4, 32'h0);
    rd("rd_rsvd", 3'd7, 32'h0);

    // 4-cycle pulse with interrupt
    wr(3'd0, 32'h00);
    wr(3'd5, 32'h4);
    wr(3'd2, 32'h1);
    rd("ctrl_rd", 3'd2, 32'h1);
    wr(3'd6, 32'h01);
    check("p4_c1", {24'd0, out_port}, 32'h01);
    rd("p4_busy", 3'd1, 32'h1);
    rd("p4_mask", 3'd6, 32'h01);
    run("p4_on", 8'h01, 3);
    run("p4_off", 8'h00, 1);
    rd("p4_done", 3'd1, 32'h2);
    check("p4_irq", {31'd0, irq}, 32'h1);
    rd("p4_mask_idle", 3'd6, 32'h0);
    wr(3'd1, 32'h2);
    check("p4_irq_clr", {31'd0, irq}, 32'h0);
    rd("p4_status_clr", 3'd1, 32'h0);

    // PULSE_LEN=0 behaves as 1
    wr(3'd5, 32'h0);
    rd("plen0_rd", 3'd5, 32'h0);
    wr(3'd6, 32'h80);
    check("p0_c1", {24'd0, out_port}, 32'h80);
    run("p0_off", 8'h00, 1);
    rd("p0_done", 3'd1, 32'h2);

    // zero mask ignored
    wr(3'd1, 32'h2);
    wr(3'd6, 32'h100);
    rd("zmask_status", 3'd1, 32'h0);
    check("zmask_out", {24'd0, out_port}, 32'h0);

    // 10-cycle pulse, retrigger ignored, DONE set beats clear
    wr(3'd5, 32'd10);
    wr(3'd6, 32'h0F);
    check("p10_c1", {24'd0, out_port}, 32'h0F);
    wr(3'd6, 32'hF0);
    check("p10_retrig", {24'd0, out_port}, 32'h0F);
    run("p10_on", 8'h0F, 8);
    wr(3'd1, 32'h2);
    check("p10_off", {24'd0, out_port}, 32'h00);
    rd("p10_done_wins", 3'd1, 32'h2);

    // base change and PULSE_LEN change during an 8-cycle pulse
    wr(3'd1, 32'h2);
    wr(3'd5, 32'd8);
    wr(3'd6, 32'h01);
    check("p8_c1", {24'd0, out_port}, 32'h01);
    run("p8_c2", 8'h01, 1);
    wr(3'd0, 32'h01);
    check("p8_base", {24'd0, out_port}, 32'h00);
    wr(3'd5, 32'd2);
    check("p8_c4", {24'd0, out_port}, 32'h00);
    run("p8_rest", 8'h00, 4);
    run("p8_after", 8'h01, 1);
    rd("p8_plen", 3'd5, 32'h2);
    rd("p8_done", 3'd1, 32'h2);
    check("p8_irq", {31'd0, irq}, 32'h1);

    // reset mid-pulse with a simultaneous write
    wr(3'd0, 32'h3C);
    wr(3'd5, 32'd10);
    wr(3'd6, 32'h01);
    check("pr_c1", {24'd0, out_port}, 32'h3D);
    run("pr_c2", 8'h3D, 2);
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("pr_out", {24'd0, out_port}, 32'h0);
    check("pr_irq", {31'd0, irq}, 32'h0);
    rd("pr_status", 3'd1, 32'h0);
    rd("pr_ctrl", 3'd2, 32'h0);
    rd("pr_plen", 3'd5, 32'h1);
    run("pr_idle", 8'h00, 12);
    rd("pr_no_done", 3'd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios_pio_pulse_out.md
NIOS_PIO_PULSE_OUT -- requirements
Module: nios_pio_pulse_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of output bits (legal 1..32).
REQ-002 SHALL have parameter PULSE_W, default 16, pulse-length counter width (legal 1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, reset value of DATA (WIDTH bits).
REQ-004 SHALL have parameter PULSE_DEFAULT, default 1, reset value of PULSE_LEN.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  3  Avalon-MM register word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  combinational read data for the current address; zero-wait.
REQ-012 out_port  output  WIDTH  driven output pins.
REQ-013 irq  output  1  level interrupt = DONE & IRQ_EN.

Function
REQ-014 Register map: 0 DATA (RW), 1 STATUS, 2 CONTROL (RW, bit0 IRQ_EN), 3 OUTSET (WO), 4 OUTCLR (WO), 5 PULSE_LEN (RW), 6 PULSE (WO-trigger, reads active mask), 7 reserved.
REQ-015 DATA write SHALL load writedata[WIDTH-1:0]; upper bits ignored.
REQ-016 OUTSET write SHALL set DATA = DATA | writedata[WIDTH-1:0]; OUTCLR write SHALL set DATA = DATA & ~writedata[WIDTH-1:0]; both read as 0.
REQ-017 STATUS read: bit0 BUSY (pulse active), bit1 DONE (sticky); writing 1 to bit1 SHALL clear DONE; other bits read 0 and ignore writes.
REQ-018 PULSE_LEN SHALL hold PULSE_W bits; a value of 0 SHALL be treated as 1.
REQ-019 PULSE write with nonzero mask while not BUSY SHALL capture MASK = writedata[WIDTH-1:0] and load counter with max(PULSE_LEN,1); BUSY=1 from the next cycle.
REQ-020 PULSE write while BUSY, or with zero mask, SHALL be ignored (no state change).
REQ-021 out_port SHALL equal DATA ^ (BUSY ? MASK : 0), registered-state only, no combinational path from writedata.
REQ-022 While BUSY the counter SHALL decrement each cycle; the pulse SHALL be visible on out_port for exactly max(PULSE_LEN,1) cycles.
REQ-023 On the edge where counter goes 1->0: BUSY<=0, MASK<=0, DONE<=1.
REQ-024 DATA/OUTSET/OUTCLR writes during a pulse SHALL take effect on the base value immediately; the pulse mask continues inverting the new base.
REQ-025 DONE set and DONE-clear write in the same cycle: set wins.
REQ-026 PULSE_LEN write during a pulse SHALL not affect the running pulse.
REQ-027 Reads of address 7 and write-only registers SHALL return 0; readdata bits above WIDTH/PULSE_W SHALL be 0.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 When reset=1 at a rising edge: DATA=RESET_VALUE, PULSE_LEN=PULSE_DEFAULT, MASK=0, counter=0, BUSY=0, DONE=0, IRQ_EN=0; hence out_port=RESET_VALUE, irq=0.
REQ-030 Reset asserted mid-pulse SHALL abort the pulse without setting DONE; reset has priority over any simultaneous write.

Verification
REQ-031 Reset, then write DATA=0xA5 -> out_port=0xA5 next cycle; read addr0 = 0x000000A5.
REQ-032 DATA=0xF0; OUTSET 0x03 -> 0xF3; OUTCLR 0x30 -> 0xC3; reads of addr3/4 = 0.
REQ-033 DATA=0x00, PULSE_LEN=4, IRQ_EN=1, PULSE 0x01 -> out_port=0x01 for exactly 4 cycles then 0x00; STATUS=0x2, irq=1; write STATUS 0x2 -> irq=0.
REQ-034 PULSE_LEN=0, PULSE 0x80 -> bit7 high exactly 1 cycle, DONE=1; second PULSE during a 10-cycle pulse -> ignored, length unchanged.
REQ-035 During 8-cycle pulse mask 0x01, write DATA=0x01 -> out_port=0x00 for remainder, 0x01 after; PULSE_LEN write to 2 mid-pulse -> pulse still 8 cycles.
REQ-036 Reset asserted at cycle 3 of a 10-cycle pulse -> out_port=RESET_VALUE, BUSY=0, DONE=0, irq=0 next cycle.
